vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Raster timing source driving draw_tetris: produces pixel coordinates, active-area flag and
//  HSYNC/VSYNC for a 1280x800@60 CVT mode (pixel clock 83.46 MHz).
//  Sync outputs are delayed to line up with the renderer's colour output.
//  Emits one-cycle frame and line event pulses for game/animation logic in the same clock domain.
// PARAMETERS
//  H_ACTIVE     1280  visible pixels per line
//  H_FRONT      64    horizontal front porch (clocks)
//  H_SYNC       136   horizontal sync width
//  H_BACK       200   horizontal back porch; H_TOTAL = 1680
//  V_ACTIVE     800   visible lines
//  V_FRONT      1     vertical front porch (lines)
//  V_SYNC       3     vertical sync width
//  V_BACK       24    vertical back porch; V_TOTAL = 828
//  H_POL        0     hsync active level (0 = active-low)
//  V_POL        1     vsync active level (1 = active-high)
//  SYNC_DELAY   1     pipeline stages on hsync/vsync/de_dly (0..4), equal to renderer latency
// PORTS
//  clk          in   1   pixel clock
//  rst_n        in   1   asynchronous active-low reset
//  curr_x       out  11  horizontal count 0..H_TOTAL-1
//  curr_y       out  10  vertical count 0..V_TOTAL-1
//  active_area  out  1   curr_x<H_ACTIVE && curr_y<V_ACTIVE, same cycle as curr_x/curr_y
//  line_start   out  1   1-cycle pulse when curr_x==0
//  frame_start  out  1   1-cycle pulse when curr_x==0 && curr_y==0
//  vblank_start out  1   1-cycle pulse when curr_x==0 && curr_y==V_ACTIVE (game-update tick)
//  frame_count  out  16  frames completed, wraps 0xFFFF->0
//  hsync        out  1   horizontal sync, delayed SYNC_DELAY cycles
//  vsync        out  1   vertical sync, delayed SYNC_DELAY cycles
//  de_dly       out  1   active_area delayed SYNC_DELAY cycles (gates colour at the pins)
// BEHAVIOUR
//  - One clock, clk; rst_n asynchronous active-low. All outputs registered.
//  - Reset: curr_x=0, curr_y=0, active_area=0, all pulses=0, frame_count=0.
//    hsync=~H_POL, vsync=~V_POL (inactive), de_dly=0, including every delay stage.
//  - First post-reset edge: curr_x=0, curr_y=0, active_area=1, line_start=1, frame_start=1.
//    The reset state itself is not a valid pixel.
//  - Counting: curr_x increments each cycle.
//    At H_TOTAL-1 it wraps to 0 and curr_y increments.
//    At (H_TOTAL-1, V_TOTAL-1) both wrap to 0 and frame_count increments in the same cycle.
//  - Coordinate outputs, active_area and pulses are computed from the next-count values.
//    For any cycle, all of them describe the same (x,y); there is no skew between them.
//  - Raw sync, before the delay line, is derived from the same next-count values:
//    - hsync active when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC (1344..1479).
//    - vsync active when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC (801..803).
//    - vsync changes only at x==0 boundaries.
//  - Delay line: raw hsync/vsync/active_area pass through SYNC_DELAY flops.
//    With SYNC_DELAY=0 they equal the undelayed values.
//  - Arithmetic: counters are unsigned with no signed intermediates.
//    Compare against parameters sized to counter width.
//    The parameter sums H_TOTAL, V_TOTAL must fit 11/10 bits; elaboration asserts this.
//  - Reset mid-frame: everything returns to reset values immediately (asynchronous).
//    The delay line is also cleared, so no stale sync pulse emerges after release.
//  - Pulses never exceed one cycle.
//    frame_start and line_start coincide at (0,0).
//    vblank_start never coincides with frame_start.
// STRUCTURE
//  - Shared package (GLOBAL.sv): H_/V_ timing constants for the 1280x800 mode.
//    Also the derived H_TOTAL and V_TOTAL; draw_tetris uses the same screen size.
//  - Sub-module: sync_delay, a generic N-stage, W-bit shift register with async reset value.
//    Instantiated once with W=3 for {hsync,vsync,de}.
//  - Counter and decode logic stay in vga_timing_gen.
// TESTING
//  - Reset release -> next edge curr_x=0, curr_y=0, active_area=1, frame_start=1.
//    During reset hsync=1 and vsync=0.
//  - Run one line -> curr_x reaches 1679 then 0 and curr_y goes 0->1.
//    active_area falls exactly at x=1280; line_start fires every 1680 clocks.
//  - With SYNC_DELAY=1, hsync goes low 1 cycle after curr_x==1344 and high 1 cycle after curr_x==1480.
//    Its width is 136 clocks.
//  - Full frame of 1,391,040 clocks -> frame_start period exact.
//    vblank_start at (0,800); vsync high on lines 801..803 only; frame_count increments 0->1.
//  - Assert rst_n low at (700,400) for 3 cycles -> all outputs at reset values at once.
//    Restart at (0,0); no hsync/vsync glitch in the 4 cycles after release.
//  - Force frame_count=0xFFFF via 65536-frame run or a back-door deposit -> next frame it reads 0x0000.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared timing constants for the 1280x800@60 CVT raster (83.46 MHz pixel clock).
// draw_tetris uses the same screen size, so keep these in one place.
// Also holds the coordinate/counter types used by the timing interface.
package vga_timing_gen_pkg;

    localparam int unsigned VGA_H_ACTIVE = 1280;
    localparam int unsigned VGA_H_FRONT  = 64;
    localparam int unsigned VGA_H_SYNC   = 136;
    localparam int unsigned VGA_H_BACK   = 200;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int unsigned VGA_V_ACTIVE = 800;
    localparam int unsigned VGA_V_FRONT  = 1;
    localparam int unsigned VGA_V_SYNC   = 3;
    localparam int unsigned VGA_V_BACK   = 24;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    localparam int unsigned X_W  = 11;
    localparam int unsigned Y_W  = 10;
    localparam int unsigned FC_W = 16;

    typedef logic [X_W-1:0]  x_coord_t;
    typedef logic [Y_W-1:0]  y_coord_t;
    typedef logic [FC_W-1:0] frame_cnt_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to its consumers (renderer, game logic, pins).
//   master : timing generator drives everything
//   slave  : consumers read everything
// Signals: curr_x/curr_y coordinates, active_area, line/frame/vblank event pulses,
//          frame_count, and the delayed hsync/vsync/de_dly pin-side outputs.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    x_coord_t   curr_x;
    y_coord_t   curr_y;
    logic       active_area;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    frame_cnt_t frame_count;
    logic       hsync;
    logic       vsync;
    logic       de_dly;

    modport master (
        output curr_x, curr_y, active_area, line_start, frame_start, vblank_start,
               frame_count, hsync, vsync, de_dly
    );

    modport slave (
        input  curr_x, curr_y, active_area, line_start, frame_start, vblank_start,
               frame_count, hsync, vsync, de_dly
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Generic N-stage, W-bit shift register with an asynchronous reset value.
// Ports: clk, rst_n (async active-low), d (W bits in), q (W bits out, N cycles later).
// N=0 is a straight wire.
module vga_timing_gen_sync_delay #(
    parameter int unsigned       N       = 1,
    parameter int unsigned       W       = 1,
    parameter logic [W-1:0]      RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (N == 0) begin : g_wire
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [N];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < N; i++) pipe_q[i] <= RST_VAL;
                end else begin
                    pipe_q[0] <= d;
                    for (int i = 1; i < N; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign q = pipe_q[N-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source for draw_tetris: pixel coordinates, active-area flag,
// line/frame/vblank event pulses, frame counter, and HSYNC/VSYNC/DE delayed to
// line up with the renderer's colour pipeline.
// Ports: clk (pixel clock), rst_n (async active-low), vga (vga_timing_gen_if.master).
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT    = VGA_H_FRONT,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BACK     = VGA_H_BACK,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT    = VGA_V_FRONT,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BACK     = VGA_V_BACK,
    parameter bit          H_POL      = 1'b0,
    parameter bit          V_POL      = 1'b1,
    parameter int unsigned SYNC_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W)) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the coordinate counters");
        end
        if (SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..4");
        end
    endgenerate

    localparam x_coord_t H_LAST    = x_coord_t'(H_TOTAL - 1);
    localparam x_coord_t H_ACT_END = x_coord_t'(H_ACTIVE);
    localparam x_coord_t HS_BEG    = x_coord_t'(H_ACTIVE + H_FRONT);
    localparam x_coord_t HS_END    = x_coord_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam y_coord_t V_LAST    = y_coord_t'(V_TOTAL - 1);
    localparam y_coord_t V_ACT_END = y_coord_t'(V_ACTIVE);
    localparam y_coord_t VS_BEG    = y_coord_t'(V_ACTIVE + V_FRONT);
    localparam y_coord_t VS_END    = y_coord_t'(V_ACTIVE + V_FRONT + V_SYNC);

    // run_q is low only in the reset state, which is not a real pixel: the
    // first edge after release loads (0,0) instead of advancing to (1,0).
    logic       run_q;
    x_coord_t   x_q, x_nxt;
    y_coord_t   y_q, y_nxt;
    logic       act_q, ls_q, fs_q, vbs_q;
    frame_cnt_t fc_q;
    logic       hs_raw_q, vs_raw_q;
    logic       x_wrap, y_wrap, frame_end;
    logic [2:0] dly_q;

    always_comb begin
        x_wrap    = (x_q == H_LAST);
        y_wrap    = (y_q == V_LAST);
        frame_end = run_q && x_wrap && y_wrap;
        x_nxt     = '0;
        y_nxt     = '0;
        if (run_q) begin
            x_nxt = x_wrap ? '0 : x_q + x_coord_t'(1);
            y_nxt = y_q;
            if (x_wrap) y_nxt = y_wrap ? '0 : y_q + y_coord_t'(1);
        end
    end

    // Every registered output is decoded from x_nxt/y_nxt so they all
    // describe the same pixel as curr_x/curr_y in any given cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            act_q    <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
            vbs_q    <= 1'b0;
            fc_q     <= '0;
            hs_raw_q <= ~H_POL;
            vs_raw_q <= ~V_POL;
        end else begin
            run_q    <= 1'b1;
            x_q      <= x_nxt;
            y_q      <= y_nxt;
            act_q    <= (x_nxt < H_ACT_END) && (y_nxt < V_ACT_END);
            ls_q     <= (x_nxt == '0);
            fs_q     <= (x_nxt == '0) && (y_nxt == '0);
            vbs_q    <= (x_nxt == '0) && (y_nxt == V_ACT_END);
            if (frame_end) fc_q <= fc_q + frame_cnt_t'(1);
            hs_raw_q <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? H_POL : ~H_POL;
            vs_raw_q <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? V_POL : ~V_POL;
        end
    end

    vga_timing_gen_sync_delay #(
        .N       (SYNC_DELAY),
        .W       (3),
        .RST_VAL ({~H_POL, ~V_POL, 1'b0})
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({hs_raw_q, vs_raw_q, act_q}),
        .q     (dly_q)
    );

    assign vga.curr_x       = x_q;
    assign vga.curr_y       = y_q;
    assign vga.active_area  = act_q;
    assign vga.line_start   = ls_q;
    assign vga.frame_start  = fs_q;
    assign vga.vblank_start = vbs_q;
    assign vga.frame_count  = fc_q;
    assign vga.hsync        = dly_q[2];
    assign vga.vsync        = dly_q[1];
    assign vga.de_dly       = dly_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Two instances: the production 1280x800 mode (SYNC_DELAY=1) and a shrunken
// mode (SYNC_DELAY=2, inverted polarities) whose short frames allow many full
// frames and randomly placed mid-frame resets. Both are compared every cycle
// against a model that derives everything from the cycle count since release.
module tb_vga_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, hpol, vpol, dly;
    } cfg_t;

    typedef struct {
        logic [31:0] x, y, act, ls, fs, vbs, fc, hs, vs, de;
    } obs_t;

    localparam cfg_t CFG_D = '{1280, 64, 136, 200, 800, 1, 3, 24, 0, 1, 1};
    localparam cfg_t CFG_S = '{16, 4, 6, 6, 10, 1, 3, 2, 1, 0, 2};

    logic   clk = 1'b0;
    logic   rst_n;
    longint n;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_d ();
    vga_timing_gen_if if_s ();

    vga_timing_gen dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FRONT (4), .H_SYNC (6), .H_BACK (6),
        .V_ACTIVE (10), .V_FRONT (1), .V_SYNC (3), .V_BACK (2),
        .H_POL (1'b1), .V_POL (1'b0), .SYNC_DELAY (2)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (if_s)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", tag, got, exp, n, $time);
        end
    endtask

    // Expected outputs n cycles after reset release (n=-1: held in reset).
    function automatic obs_t model(cfg_t c, longint cyc);
        obs_t   o;
        longint ht, vt, m, mx, my;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        o = '{default: '0};
        o.hs = (c.hpol == 0) ? 1 : 0;
        o.vs = (c.vpol == 0) ? 1 : 0;
        if (cyc < 0) return o;
        o.x   = 32'(cyc % ht);
        o.y   = 32'((cyc / ht) % vt);
        o.act = (o.x < c.ha && o.y < c.va) ? 1 : 0;
        o.ls  = (o.x == 0) ? 1 : 0;
        o.fs  = (o.x == 0 && o.y == 0) ? 1 : 0;
        o.vbs = (o.x == 0 && o.y == c.va) ? 1 : 0;
        o.fc  = 32'((cyc / (ht * vt)) % 65536);
        m = cyc - c.dly;
        if (m >= 0) begin
            mx = m % ht;
            my = (m / ht) % vt;
            if (mx >= c.ha + c.hf && mx < c.ha + c.hf + c.hs) o.hs = c.hpol;
            if (my >= c.va + c.vf && my < c.va + c.vf + c.vs) o.vs = c.vpol;
            o.de = (mx < c.ha && my < c.va) ? 1 : 0;
        end
        return o;
    endfunction

    task automatic compare(input string who, input obs_t got, input obs_t exp);
        chk_eq({who, ".curr_x"},       got.x,   exp.x);
        chk_eq({who, ".curr_y"},       got.y,   exp.y);
        chk_eq({who, ".active_area"},  got.act, exp.act);
        chk_eq({who, ".line_start"},   got.ls,  exp.ls);
        chk_eq({who, ".frame_start"},  got.fs,  exp.fs);
        chk_eq({who, ".vblank_start"}, got.vbs, exp.vbs);
        chk_eq({who, ".frame_count"},  got.fc,  exp.fc);
        chk_eq({who, ".hsync"},        got.hs,  exp.hs);
        chk_eq({who, ".vsync"},        got.vs,  exp.vs);
        chk_eq({who, ".de_dly"},       got.de,  exp.de);
    endtask

    task automatic check_all();
        obs_t g;
        g.x = 32'(if_d.curr_x);       g.y = 32'(if_d.curr_y);
        g.act = 32'(if_d.active_area); g.ls = 32'(if_d.line_start);
        g.fs = 32'(if_d.frame_start);  g.vbs = 32'(if_d.vblank_start);
        g.fc = 32'(if_d.frame_count);  g.hs = 32'(if_d.hsync);
        g.vs = 32'(if_d.vsync);        g.de = 32'(if_d.de_dly);
        compare("d", g, model(CFG_D, n));
        g.x = 32'(if_s.curr_x);       g.y = 32'(if_s.curr_y);
        g.act = 32'(if_s.active_area); g.ls = 32'(if_s.line_start);
        g.fs = 32'(if_s.frame_start);  g.vbs = 32'(if_s.vblank_start);
        g.fc = 32'(if_s.frame_count);  g.hs = 32'(if_s.hsync);
        g.vs = 32'(if_s.vsync);        g.de = 32'(if_s.de_dly);
        compare("s", g, model(CFG_S, n));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) n++;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        n     = -1;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Long uninterrupted run: ~12 production lines, ~39 small frames.
        repeat (20000) step();

        // Mid-frame resets at random points; the async clear is checked
        // before any clock edge, then held for 1..4 cycles.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(4000, 50)) step();
            rst_n = 1'b0;
            #1;
            n = -1;
            check_all();
            repeat ($urandom_range(4, 1)) step();
            rst_n = 1'b1;
        end

        repeat (3000) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
